alu_wide_seq: RTL
=================

Name: alu_wide_seq

Overview:
- Multi-cycle sequencer that runs N-byte add, subtract and 1-bit shift operations on the shared 8-bit combinational ALU.
- Issues one byte per cycle and chains the ALU's OVERFLOW_OUT back into OVERFLOW_IN between bytes.
- Sits between the core control and the ALU. It owns the ALU inputs only while BUSY is high.

Parameters:
NBYTES, 4, operand width in bytes (≥2); the wide word is 8*NBYTES bits.

Ports:
CLK  in  1  clock
RST_N  in  1  asynchronous active-low reset
START  in  1  request; accepted only in IDLE
OPSEL  in  2  wop_e: WADD=0, WSUB=1, WSHL=2, WSHR=3
A  in  8*NBYTES  operand A
B  in  8*NBYTES  operand B (ignored for shifts)
CIN  in  1  add carry-in / subtract borrow-in / shift fill bit
BUSY  out  1  high in RUN and DONE states
DONE  out  1  one-cycle pulse, RESULT/COUT valid
RESULT  out  8*NBYTES  result, held until next accept
COUT  out  1  add carry / subtract borrow / shifted-out bit
ALU_A  out  8  to ALU INPUTA
ALU_B  out  8  to ALU INPUTB
ALU_OP  out  3  to ALU OP
ALU_FUNC  out  3  to ALU FUNC
ALU_FLAG_IN  out  1  to ALU FLAG_IN, tied 0
ALU_OVF_IN  out  1  to ALU OVERFLOW_IN
ALU_OUT  in  8  from ALU OUT
ALU_OVF_OUT  in  1  from ALU OVERFLOW_OUT

Behaviour:
- Reset (async, any state): state=IDLE, idx=0, BUSY=0, DONE=0, RESULT=0, COUT=0, carry reg=0, operand regs=0.
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - START=1 at a clock edge latches A, B, OPSEL and CIN.
  - The same edge sets idx=0 and moves to RUN.
  - Carry reg is loaded with ~CIN for WSUB and with CIN for all other ops.
- RUN: one byte per cycle; the edge writes the ALU_OUT byte into the result reg, carry←ALU_OVF_OUT and idx←idx+1.
  - At idx=NBYTES-1 the edge moves to DONE.
- DONE: lasts one cycle with DONE=1, then returns to IDLE. RESULT and COUT then hold.
- Latency: DONE is high in cycle NBYTES+1 after the accept edge. Throughput is one op per NBYTES+2 cycles.
- Byte order:
  - WADD, WSUB, WSHL: byte lane = idx, LSB first.
  - WSHR: lane = NBYTES-1-idx, MSB first.
- ALU drive in RUN:
  - WADD: ALU_OP=opADD, ALU_A=A lane, ALU_B=B lane.
  - WSUB: ALU_OP=opADD, ALU_B=~B lane, so SUB is done as A+~B+carry. The ALU opSUB encoding is never used.
  - WSHL: ALU_OP=opOTYPE, ALU_FUNC=fnSHIFTL_O, ALU_B=0.
  - WSHR: ALU_OP=opOTYPE, ALU_FUNC=fnSHIFTR_O, ALU_B=0.
  - ALU_OVF_IN = carry reg in all four ops.
- ALU drive outside RUN: ALU_A=ALU_B=0, ALU_OP=opADD, ALU_FUNC=0, ALU_OVF_IN=0.
- COUT:
  - For WSUB, COUT = ~final carry (1 = borrow).
  - For all other ops, COUT = final carry.
  - COUT is registered on the last RUN edge.
- START while BUSY=1 is ignored, with no queuing and no latched-operand change.
- Operand inputs may change after the accept edge without effect.
- Reset mid-operation aborts the op: no DONE pulse, RESULT cleared.
- The ALU is purely combinational. All block outputs except the ALU_* drive are registered.

Decomposition:
- Shared package definitions gains the wop_e enum and constant opOTYPE, the O-type opcode value decoded by the ALU default branch.
- The package also supplies the existing constants opADD, fnSHIFTL_O and fnSHIFTR_O.
- There are no sub-modules. The bench instantiates ALU alongside alu_wide_seq.

Test Plan:
- WADD A=0x00FFFFFF B=0x00000001 CIN=0 -> RESULT=0x01000000, COUT=0, DONE 5 cycles after accept, BUSY high 5 cycles.
- WSUB A=0x00000000 B=0x00000001 CIN=0 -> RESULT=0xFFFFFFFF, COUT=1; A=0x00000005 B=0x00000003 -> 0x00000002, COUT=0.
- WSHL A=0x80000001 CIN=1 -> RESULT=0x00000003, COUT=1; WSHR A=0x80000001 CIN=0 -> RESULT=0x40000000, COUT=1.
- WADD 0xFFFFFFFF+0x00000001 CIN=1 -> RESULT=0x00000001, COUT=1; a second START asserted during BUSY is ignored and RESULT is unchanged.
- RST_N low during RUN (idx=2) -> immediately IDLE, BUSY=0, RESULT=0, no DONE pulse; the next START completes normally.
- Back-to-back: START held high continuously -> a new op is accepted every NBYTES+2 cycles, and each DONE carries that op's correct RESULT.

Source files
------------

// File: rtl/alu_wide_seq_pkg.sv
// Shared definitions for the wide-word ALU sequencer.
// ALU opcode/function constants plus the wide-op and FSM enums.
package alu_wide_seq_pkg;

    localparam logic [2:0] opADD   = 3'd0;
    localparam logic [2:0] opSUB   = 3'd1;
    localparam logic [2:0] opAND   = 3'd2;
    localparam logic [2:0] opSEL   = 3'd3;
    // O-type ops fall into the ALU default branch and are chosen by FUNC
    localparam logic [2:0] opOTYPE = 3'd7;

    localparam logic [2:0] fnSHIFTL_O = 3'd1;
    localparam logic [2:0] fnSHIFTR_O = 3'd2;

    typedef enum logic [1:0] {
        WADD = 2'd0,
        WSUB = 2'd1,
        WSHL = 2'd2,
        WSHR = 2'd3
    } wop_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/alu_wide_seq_alu.sv
// Shared 8-bit combinational ALU driven by the wide sequencer.
// OVERFLOW_IN/OUT act as carry in/out and as the shift fill/out bit.
module alu_wide_seq_alu
    import alu_wide_seq_pkg::*;
(
    input  logic [7:0] i_inputa,
    input  logic [7:0] i_inputb,
    input  logic [2:0] i_op,
    input  logic [2:0] i_func,
    input  logic       i_flag_in,
    input  logic       i_overflow_in,
    output logic [7:0] o_out,
    output logic       o_overflow_out
);

    // Opcode decode; unknown opcodes are O-type and select on FUNC
    always_comb begin
        o_out          = '0;
        o_overflow_out = 1'b0;
        case (i_op)
            opADD: {o_overflow_out, o_out} = {1'b0, i_inputa}
                                           + {1'b0, i_inputb}
                                           + {8'b0, i_overflow_in};
            opSUB: {o_overflow_out, o_out} = {1'b0, i_inputa}
                                           - {1'b0, i_inputb}
                                           - {8'b0, i_overflow_in};
            opAND: o_out = i_inputa & i_inputb;
            opSEL: o_out = i_flag_in ? i_inputb : i_inputa;
            default: begin
                case (i_func)
                    fnSHIFTL_O: {o_overflow_out, o_out} =
                                {i_inputa, i_overflow_in};
                    fnSHIFTR_O: {o_out, o_overflow_out} =
                                {i_overflow_in, i_inputa};
                    default:    o_out = ~i_inputa;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/alu_wide_seq.sv
// N-byte add/sub/shift sequencer over the shared 8-bit ALU.
// One byte per cycle, carry chained through a register between bytes.
module alu_wide_seq
    import alu_wide_seq_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_start,
    input  logic [1:0]          i_opsel,
    input  logic [8*NBYTES-1:0] i_a,
    input  logic [8*NBYTES-1:0] i_b,
    input  logic                i_cin,
    output logic                o_busy,
    output logic                o_done,
    output logic [8*NBYTES-1:0] o_result,
    output logic                o_cout,
    output logic [7:0]          o_alu_a,
    output logic [7:0]          o_alu_b,
    output logic [2:0]          o_alu_op,
    output logic [2:0]          o_alu_func,
    output logic                o_alu_flag_in,
    output logic                o_alu_ovf_in,
    input  logic [7:0]          i_alu_out,
    input  logic                i_alu_ovf_out
);

    localparam int W  = 8 * NBYTES;
    localparam int IW = $clog2(NBYTES);

    state_e          r_state;
    state_e          w_next;
    wop_e            r_op;
    logic [IW-1:0]   r_idx;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [W-1:0]    r_result;
    logic            r_carry;
    logic            r_cout;
    logic            r_busy;
    logic            r_done;
    logic            w_accept;
    logic            w_last;
    logic [IW-1:0]   w_lane;
    logic [7:0]      w_abyte;
    logic [7:0]      w_bbyte;

    assign w_accept = (r_state == S_IDLE) && i_start;
    assign w_last   = (r_idx == IW'(NBYTES - 1));

    // Right shifts walk MSB first so the fill bit enters at the top
    always_comb begin
        w_lane  = (r_op == WSHR) ? IW'(NBYTES - 1) - r_idx : r_idx;
        w_abyte = 8'(r_a >> {w_lane, 3'b000});
        w_bbyte = 8'(r_b >> {w_lane, 3'b000});
    end

    // Next-state logic for IDLE -> RUN (NBYTES cycles) -> DONE
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_next = S_RUN;
            S_RUN:   if (w_last)  w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // State register with registered BUSY/DONE taken from next state
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next != S_IDLE);
            r_done  <= (w_next == S_DONE);
        end
    end

    // Operand latch on accept, byte write-back and carry chain in RUN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_op     <= WADD;
            r_idx    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_carry  <= 1'b0;
            r_cout   <= 1'b0;
        end else if (w_accept) begin
            r_op    <= wop_e'(i_opsel);
            r_a     <= i_a;
            r_b     <= i_b;
            r_idx   <= '0;
            r_carry <= (wop_e'(i_opsel) == WSUB) ? ~i_cin : i_cin;
        end else if (r_state == S_RUN) begin
            for (int k = 0; k < NBYTES; k++) begin
                if (w_lane == IW'(k)) r_result[k*8 +: 8] <= i_alu_out;
            end
            r_carry <= i_alu_ovf_out;
            r_idx   <= w_last ? '0 : r_idx + 1'b1;
            if (w_last) begin
                r_cout <= (r_op == WSUB) ? ~i_alu_ovf_out : i_alu_ovf_out;
            end
        end
    end

    // ALU drive: owned only in RUN, idle-safe constants otherwise
    always_comb begin
        o_alu_a      = '0;
        o_alu_b      = '0;
        o_alu_op     = opADD;
        o_alu_func   = '0;
        o_alu_ovf_in = 1'b0;
        if (r_state == S_RUN) begin
            o_alu_a      = w_abyte;
            o_alu_ovf_in = r_carry;
            case (r_op)
                WADD: o_alu_b = w_bbyte;
                WSUB: o_alu_b = ~w_bbyte;
                WSHL: begin
                    o_alu_op   = opOTYPE;
                    o_alu_func = fnSHIFTL_O;
                end
                WSHR: begin
                    o_alu_op   = opOTYPE;
                    o_alu_func = fnSHIFTR_O;
                end
                default: o_alu_b = w_bbyte;
            endcase
        end
    end

    assign o_alu_flag_in = 1'b0;
    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_result      = r_result;
    assign o_cout        = r_cout;

endmodule
